// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared types and constants for the instruction fetch unit.
package ifetch_pkg;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;
    typedef enum logic [1:0] {IDLE, RUN, ERR} ifetch_state_e;
endpackage

// File: rtl/ifetch_if.sv
// ifetch_if: imem read port, redirect input and decode stream of the fetch unit.
interface ifetch_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_word;
    logic [31:0] inst_pc;
    logic        misalign_err;
    modport master (
        output imem_addr, inst_valid, inst_word, inst_pc, misalign_err,
        input  imem_rdata, redirect_valid, redirect_pc, inst_ready
    );
    modport slave (
        input  imem_addr, inst_valid, inst_word, inst_pc, misalign_err,
        output imem_rdata, redirect_valid, redirect_pc, inst_ready
    );
endinterface

// File: rtl/ifetch_fifo.sv
// ifetch_fifo: synchronous FIFO of {pc, instr} entries; flush wins over push/pop.
module ifetch_fifo
    import ifetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_flush,
    input  fetch_entry_t             i_data,
    output fetch_entry_t             o_head,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);
    fetch_entry_t   r_mem [DEPTH];
    logic [AW-1:0]  r_wr;
    logic [AW-1:0]  r_rd;
    logic [AW:0]    r_count;
    always_ff @(posedge clk)
        if (i_push) r_mem[r_wr] <= i_data;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_wr <= r_wr + AW'(1);
            if (i_pop) r_rd <= r_rd + AW'(1);
            r_count <= r_count + (AW+1)'(i_push) - (AW+1)'(i_pop);
        end
    end
    assign o_head  = r_mem[r_rd];
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
endmodule

// File: rtl/ifetch_unit.sv
// ifetch_unit: fetch PC, imem request, prefetch buffering and redirect handling.
// Define IFETCH_MISALIGN_TRAP_EN to trap misaligned redirects into a sticky ERR state.
module ifetch_unit
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input logic      clk,
    input logic      reset,
    ifetch_if.master bus
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    ifetch_state_e r_state;
    ifetch_state_e w_next;
    logic [31:0]   r_pc;
    logic [31:0]   w_target;
    logic          w_redirect;
    logic          w_misalign;
    logic          w_push;
    logic          w_pop;
    logic          w_empty;
    logic [CW-1:0] w_count;
    fetch_entry_t  w_head;
    fetch_entry_t  w_entry;
`ifdef IFETCH_MISALIGN_TRAP_EN
    logic r_err;
    assign w_misalign = w_redirect && (bus.redirect_pc[1:0] != 2'b00);
    assign w_target   = bus.redirect_pc;
    always_ff @(posedge clk or posedge reset)
        if (reset) r_err <= 1'b0;
        else if (w_misalign) r_err <= 1'b1;
    assign bus.misalign_err = r_err;
`else
    assign w_misalign       = 1'b0;
    assign w_target         = bus.redirect_pc & ~32'h3;
    assign bus.misalign_err = 1'b0;
`endif
    always_ff @(posedge clk or posedge reset)
        if (reset) r_state <= IDLE;
        else r_state <= w_next;
    // IDLE exists only to keep the reset-release edge free of pushes
    always_comb
        w_next = w_misalign ? ERR : (r_state == IDLE) ? RUN : r_state;
    always_comb begin
        w_redirect     = bus.redirect_valid && (r_state != ERR);
        w_pop          = !w_empty && bus.inst_ready;
        w_push         = (r_state == RUN) && !w_redirect && ((w_count != CW'(FIFO_DEPTH)) || w_pop);
        bus.imem_addr  = r_pc;
        bus.inst_valid = !w_empty;
        bus.inst_word  = w_empty ? NOP_INSTR : w_head.instr;
        bus.inst_pc    = w_empty ? 32'h0 : w_head.pc;
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) r_pc <= RESET_PC;
        else if (w_redirect) r_pc <= w_target;
        else if (w_push) r_pc <= r_pc + 32'd4;
    assign w_entry = '{pc: r_pc, instr: bus.imem_rdata};
    ifetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (w_redirect),
        .i_data  (w_entry),
        .o_head  (w_head),
        .o_empty (w_empty),
        .o_count (w_count)
    );
endmodule
